mem_stage_mc: RTL and testbench
===============================

MEM_STAGE_MC -- requirements
Module: mem_stage_mc

Interface
REQ-001 The block SHALL have parameter DW, default 16: data, address and PC width.
REQ-002 The block SHALL have parameter TIMEOUT, default 15: maximum cycles mem_req is held before abort (range 1..255).
REQ-003 The block SHALL have parameter IMM_SHIFT, default 1: left shift applied to the branch immediate.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  the single clock, rising edge.
REQ-006 rst  in  1  synchronous active-low reset.
REQ-007 valid_in  in  1  instruction present this cycle.
REQ-008 pc_inc  in  DW  PC+2 of the instruction.
REQ-009 imm_sel  in  1  1 selects imm11_ext, 0 selects imm8_ext.
REQ-010 imm8_ext, imm11_ext  in  DW each  sign-extended immediates.
REQ-011 alu_result  in  DW  effective address or jump target.
REQ-012 alu_jump, brch_cnd  in  1 each  register jump; branch taken.
REQ-013 mem_enable, mem_write  in  1 each  memory access; access is a store.
REQ-014 wr_data  in  DW  store data.
REQ-015 halt  in  1  HALT instruction.
REQ-016 stall  out  1  upstream must hold; block accepts nothing.
REQ-017 valid_out, next_pc, read_data, err  out  1/DW/DW/1  result strobe, next PC, load data, misalign or timeout.
REQ-018 halted  out  1  sticky after HALT; dump  out  1  one-cycle createdump pulse.
REQ-019 mem_req, mem_wr, mem_addr, mem_wdata  out  1/1/DW/DW  backing-memory request.
REQ-020 mem_done  in  1  memory complete; mem_rdata  in  DW  load data.

Function
REQ-021 Acceptance SHALL occur when valid_in=1, state IDLE and halted=0; otherwise valid_in SHALL be ignored.
REQ-022 Accepted next_pc SHALL be alu_jump ? alu_result : brch_cnd ? pc_inc+(imm<<IMM_SHIFT) : pc_inc, mod 2^DW; the jump takes priority over the branch.
REQ-023 next_pc SHALL be registered at acceptance and presented with valid_out.
REQ-024 States: IDLE, BUSY. IDLE -> BUSY on accepted mem_enable with alu_result[0]=0; BUSY -> IDLE on mem_done or timeout.
REQ-025 A non-memory instruction SHALL produce valid_out=1 exactly one cycle after acceptance, with read_data=0 and err=0.
REQ-026 A misaligned access (alu_result[0]=1) SHALL issue no mem_req and SHALL produce valid_out=1 with err=1 and read_data=0 one cycle after acceptance.
REQ-027 In BUSY, mem_req=1 SHALL hold, and mem_addr, mem_wr and mem_wdata SHALL stay stable, from the cycle after acceptance through the cycle mem_done is sampled high.
REQ-028 mem_done SHALL be ignored when mem_req=0.
REQ-029 The cycle after mem_done, the block SHALL drive valid_out=1; read_data SHALL be mem_rdata for a load and 0 for a store.
REQ-030 stall SHALL equal (state==BUSY), combinationally.
REQ-031 The wait counter SHALL reset on entering BUSY; if TIMEOUT cycles elapse without mem_done, the block SHALL drop mem_req, go to IDLE, and pulse valid_out with err=1.
REQ-032 valid_out and dump SHALL be single-cycle pulses.
REQ-033 An accepted halt SHALL pulse dump one cycle after acceptance and SHALL set halted.
REQ-034 halted SHALL stay set until reset; later valid_in SHALL be ignored.
REQ-035 halt with mem_enable SHALL complete the access first, then assert dump together with valid_out.

Reset
REQ-036 When rst=0 at a clock edge: state IDLE, counter 0, and every output 0.
REQ-037 Reset mid-BUSY SHALL abandon the access: mem_req=0 next cycle, with no valid_out.

Structure
REQ-038 Package mem_stage_pkg SHALL hold the state enum and DW/TIMEOUT defaults.
REQ-039 Next-PC arithmetic SHALL be a combinational sub-module, pc_target_calc.

Verification
REQ-040 Branch: pc_inc=0x0010, imm8_ext=0xFFFE, brch_cnd=1, imm_sel=0 -> valid_out next cycle, next_pc=0x000C.
REQ-041 Load: alu_result=0x0040, memory answers mem_done with mem_rdata=0xBEEF on the 3rd mem_req cycle -> stall held 3 cycles, then read_data=0xBEEF, err=0.
REQ-042 Misaligned: store to 0x0041 -> no mem_req; valid_out=1 and err=1 next cycle.
REQ-043 Timeout: TIMEOUT=4, mem_done never asserts -> mem_req high exactly 4 cycles, then valid_out=1 with err=1.
REQ-044 Halt: valid_in=1, halt=1 -> dump pulses once, halted=1; a subsequent load produces no mem_req.
REQ-045 Reset at BUSY cycle 2 -> mem_req=0 and valid_out=0 the following cycle; state IDLE.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and default sizes for the multi-cycle memory stage.
package mem_stage_pkg;
  localparam int DW_DEF      = 16;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/mem_stage_mc_if.sv
// Bundle of the upstream instruction bus, result bus and backing-memory request bus.
interface mem_stage_mc_if
  import mem_stage_pkg::*;
#(
  parameter int DW = DW_DEF
) ();
  // Upstream holds valid_in and its fields while stall=1; an instruction is taken
  // only in a cycle where valid_in=1 and stall=0. mem_req is held with stable
  // mem_addr/mem_wr/mem_wdata until the cycle mem_done is sampled high.
  logic          valid_in;
  logic [DW-1:0] pc_inc;
  logic          imm_sel;
  logic [DW-1:0] imm8_ext;
  logic [DW-1:0] imm11_ext;
  logic [DW-1:0] alu_result;
  logic          alu_jump;
  logic          brch_cnd;
  logic          mem_enable;
  logic          mem_write;
  logic [DW-1:0] wr_data;
  logic          halt;

  logic          stall;
  logic          valid_out;
  logic [DW-1:0] next_pc;
  logic [DW-1:0] read_data;
  logic          err;
  logic          halted;
  logic          dump;

  logic          mem_req;
  logic          mem_wr;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;

  state_t        dbg_state;

  modport slave (
    input  valid_in, pc_inc, imm_sel, imm8_ext, imm11_ext, alu_result, alu_jump,
           brch_cnd, mem_enable, mem_write, wr_data, halt, mem_done, mem_rdata,
    output stall, valid_out, next_pc, read_data, err, halted, dump,
           mem_req, mem_wr, mem_addr, mem_wdata, dbg_state
  );

  modport master (
    output valid_in, pc_inc, imm_sel, imm8_ext, imm11_ext, alu_result, alu_jump,
           brch_cnd, mem_enable, mem_write, wr_data, halt, mem_done, mem_rdata,
    input  stall, valid_out, next_pc, read_data, err, halted, dump,
           mem_req, mem_wr, mem_addr, mem_wdata, dbg_state
  );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-PC selection: register jump, taken branch, or fall-through.
module pc_target_calc #(
  parameter int DW        = 16,
  parameter int IMM_SHIFT = 1
) (
  input  logic [DW-1:0] i_pc_inc,
  input  logic [DW-1:0] i_imm8_ext,
  input  logic [DW-1:0] i_imm11_ext,
  input  logic [DW-1:0] i_alu_result,
  input  logic          i_imm_sel,
  input  logic          i_alu_jump,
  input  logic          i_brch_cnd,
  output logic [DW-1:0] o_next_pc
);
  logic [DW-1:0] w_imm;
  logic [DW-1:0] w_branch;

  assign w_imm    = i_imm_sel ? i_imm11_ext : i_imm8_ext;
  assign w_branch = i_pc_inc + (w_imm << IMM_SHIFT);

  always_comb begin
    o_next_pc = i_pc_inc;
    if (i_alu_jump)      o_next_pc = i_alu_result;
    else if (i_brch_cnd) o_next_pc = w_branch;
  end
endmodule

// File: rtl/mem_stage_mc.sv
// Memory stage: computes next PC, runs a held request/done memory access with
// timeout, flags misalignment, and handles HALT with a one-shot dump pulse.
module mem_stage_mc
  import mem_stage_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int IMM_SHIFT = 1
) (
  input logic            clk,
  input logic            rst,
  mem_stage_mc_if.slave  bus
);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_cnt;
  logic          r_valid_out;
  logic [DW-1:0] r_next_pc;
  logic [DW-1:0] r_read_data;
  logic          r_err;
  logic          r_halted;
  logic          r_dump;
  logic          r_halt_pend;
  logic          r_mem_wr;
  logic [DW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  logic          w_accept;
  logic          w_misalign;
  logic          w_start_mem;
  logic          w_busy_end;
  logic [DW-1:0] w_target;

  pc_target_calc #(.DW(DW), .IMM_SHIFT(IMM_SHIFT)) u_pc_target_calc (
    .i_pc_inc     (bus.pc_inc),
    .i_imm8_ext   (bus.imm8_ext),
    .i_imm11_ext  (bus.imm11_ext),
    .i_alu_result (bus.alu_result),
    .i_imm_sel    (bus.imm_sel),
    .i_alu_jump   (bus.alu_jump),
    .i_brch_cnd   (bus.brch_cnd),
    .o_next_pc    (w_target)
  );

  assign w_accept    = bus.valid_in && (r_state == ST_IDLE) && !r_halted;
  assign w_misalign  = bus.alu_result[0];
  assign w_start_mem = w_accept && bus.mem_enable && !w_misalign;
  // mem_done only matters while the request is up, i.e. in BUSY.
  assign w_busy_end  = (r_state == ST_BUSY) && (bus.mem_done || (r_cnt == CNT_LAST));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_mem) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_busy_end)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt       <= 8'd0;
      r_valid_out <= 1'b0;
      r_next_pc   <= '0;
      r_read_data <= '0;
      r_err       <= 1'b0;
      r_halted    <= 1'b0;
      r_dump      <= 1'b0;
      r_halt_pend <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_valid_out <= 1'b0;
      r_dump      <= 1'b0;
      if (r_state == ST_BUSY) r_cnt <= r_cnt + 8'd1;
      if (w_accept) begin
        r_next_pc <= w_target;
        if (w_start_mem) begin
          r_cnt       <= 8'd0;
          r_mem_wr    <= bus.mem_write;
          r_mem_addr  <= bus.alu_result;
          r_mem_wdata <= bus.wr_data;
          r_halt_pend <= bus.halt;
        end else begin
          r_valid_out <= 1'b1;
          r_read_data <= '0;
          r_err       <= bus.mem_enable;
          if (bus.halt) begin
            r_dump   <= 1'b1;
            r_halted <= 1'b1;
          end
        end
      end else if (w_busy_end) begin
        // A done in the final wait cycle still counts as a good completion.
        r_valid_out <= 1'b1;
        r_err       <= !bus.mem_done;
        r_read_data <= (bus.mem_done && !r_mem_wr) ? bus.mem_rdata : '0;
        r_halt_pend <= 1'b0;
        if (r_halt_pend) begin
          r_dump   <= 1'b1;
          r_halted <= 1'b1;
        end
      end
    end
  end

  assign bus.stall     = (r_state == ST_BUSY);
  assign bus.mem_req   = (r_state == ST_BUSY);
  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.valid_out = r_valid_out;
  assign bus.next_pc   = r_next_pc;
  assign bus.read_data = r_read_data;
  assign bus.err       = r_err;
  assign bus.halted    = r_halted;
  assign bus.dump      = r_dump;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_mem_stage_mc.sv
// Directed bench for mem_stage_mc: single-cycle vector table plus memory, timeout,
// halt and reset sequences.
module tb_mem_stage_mc;
  import mem_stage_pkg::*;

  localparam int DW = 16;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mem_stage_mc_if #(.DW(DW)) bus ();

  mem_stage_mc #(.DW(DW), .TIMEOUT(4), .IMM_SHIFT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] pc_inc;
    logic [DW-1:0] imm8;
    logic [DW-1:0] imm11;
    logic          imm_sel;
    logic [DW-1:0] alu_result;
    logic          alu_jump;
    logic          brch_cnd;
    logic          mem_enable;
    logic          mem_write;
    logic [DW-1:0] exp_pc;
    logic          exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.valid_in   = 1'b0;
    bus.pc_inc     = '0;
    bus.imm_sel    = 1'b0;
    bus.imm8_ext   = '0;
    bus.imm11_ext  = '0;
    bus.alu_result = '0;
    bus.alu_jump   = 1'b0;
    bus.brch_cnd   = 1'b0;
    bus.mem_enable = 1'b0;
    bus.mem_write  = 1'b0;
    bus.wr_data    = '0;
    bus.halt       = 1'b0;
    bus.mem_done   = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  // Present one instruction for one cycle; returns one cycle after acceptance.
  task automatic issue(input logic [DW-1:0] pc, input logic [DW-1:0] addr,
                       input logic men, input logic mwr,
                       input logic [DW-1:0] wdata, input logic hlt);
    clear_inputs();
    bus.valid_in   = 1'b1;
    bus.pc_inc     = pc;
    bus.alu_result = addr;
    bus.mem_enable = men;
    bus.mem_write  = mwr;
    bus.wr_data    = wdata;
    bus.halt       = hlt;
    step();
    clear_inputs();
  endtask

  // Behaves as backing memory: answers on the done_at-th request cycle (0 = never).
  // Stops at valid_out or after a cycle budget; counts request cycles and bus changes.
  task automatic run_mem(input int done_at, input logic [DW-1:0] rdata,
                         input logic [DW-1:0] exp_addr, input logic exp_wr,
                         input logic [DW-1:0] exp_wdata,
                         output int n_req, output int n_stall, output int n_bad);
    n_req = 0;
    n_stall = 0;
    n_bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.valid_out) break;
      if (bus.stall) n_stall++;
      if (bus.mem_req) begin
        n_req++;
        if (bus.mem_addr !== exp_addr || bus.mem_wr !== exp_wr || bus.mem_wdata !== exp_wdata)
          n_bad++;
      end
      bus.mem_done  = (done_at != 0 && n_req == done_at);
      bus.mem_rdata = bus.mem_done ? rdata : 16'h0000;
      step();
    end
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
  endtask

  int n_req, n_stall, n_bad;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear_inputs();
    rst = 1'b0;
    step();
    step();

    check("rst_valid_out", 32'(bus.valid_out), 32'd0);
    check("rst_next_pc",   32'(bus.next_pc),   32'd0);
    check("rst_read_data", 32'(bus.read_data), 32'd0);
    check("rst_err",       32'(bus.err),       32'd0);
    check("rst_halted",    32'(bus.halted),    32'd0);
    check("rst_dump",      32'(bus.dump),      32'd0);
    check("rst_mem_req",   32'(bus.mem_req),   32'd0);
    check("rst_stall",     32'(bus.stall),     32'd0);
    check("rst_state",     32'(bus.dbg_state), 32'(ST_IDLE));
    rst = 1'b1;
    step();

    //            pc_inc    imm8      imm11     sel   alu       jmp   brch  men   mwr   exp_pc    err
    vecs[0] = '{16'h0010, 16'hFFFE, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h000C, 1'b0};
    vecs[1] = '{16'h0100, 16'h0004, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0};
    vecs[2] = '{16'h0100, 16'h0004, 16'h0000, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b0};
    vecs[3] = '{16'h0200, 16'h0004, 16'h0010, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0220, 1'b0};
    vecs[4] = '{16'hFFFE, 16'h0002, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0};
    vecs[5] = '{16'h0020, 16'h0000, 16'h0000, 1'b0, 16'h0041, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0020, 1'b1};
    vecs[6] = '{16'h0030, 16'h0000, 16'h0000, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0030, 1'b1};

    for (int i = 0; i < 7; i++) begin
      clear_inputs();
      bus.valid_in   = 1'b1;
      bus.pc_inc     = vecs[i].pc_inc;
      bus.imm8_ext   = vecs[i].imm8;
      bus.imm11_ext  = vecs[i].imm11;
      bus.imm_sel    = vecs[i].imm_sel;
      bus.alu_result = vecs[i].alu_result;
      bus.alu_jump   = vecs[i].alu_jump;
      bus.brch_cnd   = vecs[i].brch_cnd;
      bus.mem_enable = vecs[i].mem_enable;
      bus.mem_write  = vecs[i].mem_write;
      bus.wr_data    = 16'h5A5A;
      step();
      clear_inputs();
      check($sformatf("vec%0d_valid", i),   32'(bus.valid_out), 32'd1);
      check($sformatf("vec%0d_next_pc", i), 32'(bus.next_pc),   32'(vecs[i].exp_pc));
      check($sformatf("vec%0d_err", i),     32'(bus.err),       32'(vecs[i].exp_err));
      check($sformatf("vec%0d_rdata", i),   32'(bus.read_data), 32'd0);
      check($sformatf("vec%0d_mem_req", i), 32'(bus.mem_req),   32'd0);
      step();
      check($sformatf("vec%0d_pulse", i),   32'(bus.valid_out), 32'd0);
    end

    // mem_done while idle must not produce a result
    bus.mem_done = 1'b1;
    step();
    bus.mem_done = 1'b0;
    step();
    check("idle_done_ignored", 32'(bus.valid_out), 32'd0);

    // load answered on the third request cycle
    issue(16'h0050, 16'h0040, 1'b1, 1'b0, 16'h0000, 1'b0);
    run_mem(3, 16'hBEEF, 16'h0040, 1'b0, 16'h0000, n_req, n_stall, n_bad);
    check("load_req_cycles",   32'(n_req),         32'd3);
    check("load_stall_cycles", 32'(n_stall),       32'd3);
    check("load_bus_stable",   32'(n_bad),         32'd0);
    check("load_valid",        32'(bus.valid_out), 32'd1);
    check("load_rdata",        32'(bus.read_data), 32'hBEEF);
    check("load_err",          32'(bus.err),       32'd0);
    check("load_next_pc",      32'(bus.next_pc),   32'h0050);
    check("load_req_drop",     32'(bus.mem_req),   32'd0);
    step();
    check("load_pulse",        32'(bus.valid_out), 32'd0);

    // store: read_data stays zero even if memory drives rdata
    issue(16'h0060, 16'h0044, 1'b1, 1'b1, 16'hA5A5, 1'b0);
    run_mem(1, 16'h1111, 16'h0044, 1'b1, 16'hA5A5, n_req, n_stall, n_bad);
    check("store_req_cycles", 32'(n_req),         32'd1);
    check("store_bus_stable", 32'(n_bad),         32'd0);
    check("store_valid",      32'(bus.valid_out), 32'd1);
    check("store_rdata",      32'(bus.read_data), 32'd0);
    check("store_err",        32'(bus.err),       32'd0);
    step();

    // timeout with TIMEOUT=4
    issue(16'h0070, 16'h0060, 1'b1, 1'b0, 16'h0000, 1'b0);
    run_mem(0, 16'h0000, 16'h0060, 1'b0, 16'h0000, n_req, n_stall, n_bad);
    check("to_req_cycles", 32'(n_req),         32'd4);
    check("to_valid",      32'(bus.valid_out), 32'd1);
    check("to_err",        32'(bus.err),       32'd1);
    check("to_rdata",      32'(bus.read_data), 32'd0);
    check("to_req_drop",   32'(bus.mem_req),   32'd0);
    step();

    // done arriving in the last allowed cycle is a good completion
    issue(16'h0072, 16'h0062, 1'b1, 1'b0, 16'h0000, 1'b0);
    run_mem(4, 16'h7777, 16'h0062, 1'b0, 16'h0000, n_req, n_stall, n_bad);
    check("late_done_cycles", 32'(n_req),         32'd4);
    check("late_done_err",    32'(bus.err),       32'd0);
    check("late_done_rdata",  32'(bus.read_data), 32'h7777);
    step();

    // halt together with a load: access completes, then dump with valid_out
    issue(16'h0080, 16'h0046, 1'b1, 1'b0, 16'h0000, 1'b1);
    check("hm_no_early_dump",   32'(bus.dump),   32'd0);
    check("hm_no_early_halted", 32'(bus.halted), 32'd0);
    run_mem(2, 16'h4321, 16'h0046, 1'b0, 16'h0000, n_req, n_stall, n_bad);
    check("hm_req_cycles", 32'(n_req),         32'd2);
    check("hm_valid",      32'(bus.valid_out), 32'd1);
    check("hm_dump",       32'(bus.dump),      32'd1);
    check("hm_halted",     32'(bus.halted),    32'd1);
    check("hm_rdata",      32'(bus.read_data), 32'h4321);
    step();
    check("hm_dump_pulse", 32'(bus.dump),      32'd0);

    // reset clears halted; then reset during BUSY cycle 2
    rst = 1'b0;
    step();
    check("rst_clears_halted", 32'(bus.halted), 32'd0);
    rst = 1'b1;
    step();
    issue(16'h0090, 16'h0048, 1'b1, 1'b0, 16'h0000, 1'b0);
    check("rb_busy1_req", 32'(bus.mem_req), 32'd1);
    step();
    check("rb_busy2_req", 32'(bus.mem_req), 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("rb_req",   32'(bus.mem_req),   32'd0);
    check("rb_valid", 32'(bus.valid_out), 32'd0);
    check("rb_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    bus.mem_done = 1'b1;
    step();
    bus.mem_done = 1'b0;
    check("rb_no_late_valid", 32'(bus.valid_out), 32'd0);
    step();

    // plain halt, then a load that must be ignored
    issue(16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    check("h_dump",   32'(bus.dump),      32'd1);
    check("h_halted", 32'(bus.halted),    32'd1);
    check("h_valid",  32'(bus.valid_out), 32'd1);
    check("h_pc",     32'(bus.next_pc),   32'h00A0);
    step();
    check("h_dump_pulse", 32'(bus.dump), 32'd0);
    n_req = 0;
    n_bad = 0;
    clear_inputs();
    bus.valid_in   = 1'b1;
    bus.alu_result = 16'h0040;
    bus.mem_enable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.mem_req)   n_req++;
      if (bus.valid_out || bus.dump) n_bad++;
    end
    clear_inputs();
    check("h_load_no_req",    32'(n_req),      32'd0);
    check("h_load_no_result", 32'(n_bad),      32'd0);
    check("h_still_halted",   32'(bus.halted), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
